reg_id_ex: RTL and testbench
============================

// Module: reg_id_ex
// PURPOSE
//  ID->EX pipeline register. Sits directly downstream of StageId and feeds the EX stage.
//  Captures decoded control, operands and immediates each cycle, and tracks a valid bit.
//  Implements freeze (hold) and flush (kill) and counts bubble and freeze cycles for perf debug.
// PARAMETERS
//  DATA_W  32  width of PC and register operands
//  CNT_W   16  width of saturating perf counters
// PORTS
//  clk               in   1       clock; all state updates on posedge
//  rst               in   1       synchronous reset, ACTIVE-LOW (0 = reset), sampled on posedge clk
//  freeze            in   1       hold every stored field this cycle
//  flush             in   1       replace the captured entry with a bubble (branch taken in EX)
//  validIn           in   1       ID entry is a real instruction (0 = hazard bubble from ID)
//  pcIn/pcOut        in/out DATA_W  instruction PC+4
//  regRnIn/regRnOut  in/out DATA_W  Rn operand value
//  regRmIn/regRmOut  in/out DATA_W  Rm operand value
//  aluCmdIn/aluCmdOut in/out 4     EX ALU command
//  destIn/destOut    in/out 4      writeback destination register
//  src1In/src1Out, src2In/src2Out  in/out 4  source reg numbers (for forwarding)
//  shiftOperandIn/Out in/out 12    shifter operand
//  imm24In/imm24Out  in/out 24     branch offset
//  immIn/immOut      in/out 1      I bit
//  memReadIn, memWriteEnIn, wbEnIn, branchIn, sIn / *Out  in/out 1 each  control bits
//  validOut          out  1       stored entry is a real instruction
//  bubbleCnt         out  CNT_W   cycles a bubble was loaded
//  freezeCnt         out  CNT_W   cycles held by freeze
// BEHAVIOUR
//  - Latency: 1 cycle. Outputs are registered only; no combinational in->out path.
//  - Per posedge, the priority is: !rst > flush > freeze > load.
//  - !rst: all outputs 0, including validOut, control bits, data fields and both counters.
//  - flush=1 (freeze ignored): validOut<=0; memRead/memWriteEn/wbEn/branch/s Out<=0.
//    All data fields <=0. bubbleCnt increments.
//  - flush=0, freeze=1: every field holds, including validOut. freezeCnt increments.
//    bubbleCnt is unchanged.
//  - Load with validIn=1: all fields <= inputs; validOut<=1.
//  - Load with validIn=0: treated exactly as flush, regardless of the control inputs.
//    bubbleCnt increments.
//  - Invariant: validOut=0 implies memReadOut, memWriteEnOut, wbEnOut, branchOut and sOut are all 0.
//  - Counters saturate at 2^CNT_W-1 and never wrap. They are cleared only by reset.
//  - Simultaneous flush+freeze counts as a bubble, not a freeze.
//  - Reset asserted mid-freeze or mid-flush: reset wins in that cycle.
//    First cycle after rst=1 behaves as a normal load.
//  - No X propagation: every stored bit has a defined reset value.
// TESTING
//  1 rst=0 two cycles with random inputs -> all outputs 0 and counters 0;
//    release rst -> next edge loads pcIn=32'h4, validOut=1.
//  2 Stream 3 valid instrs (pc 4,8,C; wbEn=1, dest=1,2,3) -> outputs follow one cycle later in order.
//  3 freeze=1 for 3 cycles while the inputs change -> outputs hold pc=8, freezeCnt=3, bubbleCnt=0.
//  4 flush=1 with freeze=1 and memWriteEnIn=1 -> validOut=0, memWriteEnOut=0, regRnOut=0,
//    bubbleCnt+1, freezeCnt unchanged.
//  5 validIn=0 with wbEnIn=1, branchIn=1 -> wbEnOut=0, branchOut=0, validOut=0.
//  6 CNT_W=4, 20 consecutive flush cycles -> bubbleCnt saturates at 15; rst=0 -> 0.

Source files
------------

// File: rtl/reg_id_ex_if.sv
// ID->EX pipeline register bus: ID-side inputs, EX-side outputs and perf counters.
// master = ID/control side driving the register; slave = the register itself.
interface reg_id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              freeze;
  logic              flush;
  logic              validIn;
  logic [DATA_W-1:0] pcIn;
  logic [DATA_W-1:0] regRnIn;
  logic [DATA_W-1:0] regRmIn;
  logic [3:0]        aluCmdIn;
  logic [3:0]        destIn;
  logic [3:0]        src1In;
  logic [3:0]        src2In;
  logic [11:0]       shiftOperandIn;
  logic [23:0]       imm24In;
  logic              immIn;
  logic              memReadIn;
  logic              memWriteEnIn;
  logic              wbEnIn;
  logic              branchIn;
  logic              sIn;

  logic              validOut;
  logic [DATA_W-1:0] pcOut;
  logic [DATA_W-1:0] regRnOut;
  logic [DATA_W-1:0] regRmOut;
  logic [3:0]        aluCmdOut;
  logic [3:0]        destOut;
  logic [3:0]        src1Out;
  logic [3:0]        src2Out;
  logic [11:0]       shiftOperandOut;
  logic [23:0]       imm24Out;
  logic              immOut;
  logic              memReadOut;
  logic              memWriteEnOut;
  logic              wbEnOut;
  logic              branchOut;
  logic              sOut;
  logic [CNT_W-1:0]  bubbleCnt;
  logic [CNT_W-1:0]  freezeCnt;

  modport master (
    output freeze, flush, validIn, pcIn, regRnIn, regRmIn, aluCmdIn, destIn,
           src1In, src2In, shiftOperandIn, imm24In, immIn, memReadIn,
           memWriteEnIn, wbEnIn, branchIn, sIn,
    input  validOut, pcOut, regRnOut, regRmOut, aluCmdOut, destOut, src1Out,
           src2Out, shiftOperandOut, imm24Out, immOut, memReadOut,
           memWriteEnOut, wbEnOut, branchOut, sOut, bubbleCnt, freezeCnt
  );

  modport slave (
    input  freeze, flush, validIn, pcIn, regRnIn, regRmIn, aluCmdIn, destIn,
           src1In, src2In, shiftOperandIn, imm24In, immIn, memReadIn,
           memWriteEnIn, wbEnIn, branchIn, sIn,
    output validOut, pcOut, regRnOut, regRmOut, aluCmdOut, destOut, src1Out,
           src2Out, shiftOperandOut, imm24Out, immOut, memReadOut,
           memWriteEnOut, wbEnOut, branchOut, sOut, bubbleCnt, freezeCnt
  );
endinterface

// File: rtl/reg_id_ex.sv
// ID->EX pipeline register with freeze/flush and saturating bubble/freeze perf counters.
// Priority per edge: reset > flush > freeze > load; a load of an invalid entry is a flush.
module reg_id_ex #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst,
  reg_id_ex_if.slave bus
);
  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rn;
  logic [DATA_W-1:0] r_rm;
  logic [3:0]        r_aluCmd;
  logic [3:0]        r_dest;
  logic [3:0]        r_src1;
  logic [3:0]        r_src2;
  logic [11:0]       r_shiftOperand;
  logic [23:0]       r_imm24;
  logic              r_imm;
  logic              r_memRead;
  logic              r_memWriteEn;
  logic              r_wbEn;
  logic              r_branch;
  logic              r_s;
  logic [CNT_W-1:0]  r_bubbleCnt;
  logic [CNT_W-1:0]  r_freezeCnt;

  logic w_kill;
  logic w_hold;

  // Bubble: explicit flush, or an unfrozen load of an invalid ID entry.
  assign w_kill = bus.flush | (~bus.freeze & ~bus.validIn);
  assign w_hold = ~bus.flush & bus.freeze;

  always_ff @(posedge clk) begin
    if (!rst || w_kill) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_rn           <= '0;
      r_rm           <= '0;
      r_aluCmd       <= '0;
      r_dest         <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_shiftOperand <= '0;
      r_imm24        <= '0;
      r_imm          <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWriteEn   <= 1'b0;
      r_wbEn         <= 1'b0;
      r_branch       <= 1'b0;
      r_s            <= 1'b0;
    end else if (!w_hold) begin
      r_valid        <= 1'b1;
      r_pc           <= bus.pcIn;
      r_rn           <= bus.regRnIn;
      r_rm           <= bus.regRmIn;
      r_aluCmd       <= bus.aluCmdIn;
      r_dest         <= bus.destIn;
      r_src1         <= bus.src1In;
      r_src2         <= bus.src2In;
      r_shiftOperand <= bus.shiftOperandIn;
      r_imm24        <= bus.imm24In;
      r_imm          <= bus.immIn;
      r_memRead      <= bus.memReadIn;
      r_memWriteEn   <= bus.memWriteEnIn;
      r_wbEn         <= bus.wbEnIn;
      r_branch       <= bus.branchIn;
      r_s            <= bus.sIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bubbleCnt <= '0;
      r_freezeCnt <= '0;
    end else begin
      if (w_kill && r_bubbleCnt != '1) r_bubbleCnt <= r_bubbleCnt + 1'b1;
      if (w_hold && r_freezeCnt != '1) r_freezeCnt <= r_freezeCnt + 1'b1;
    end
  end

  assign bus.validOut        = r_valid;
  assign bus.pcOut           = r_pc;
  assign bus.regRnOut        = r_rn;
  assign bus.regRmOut        = r_rm;
  assign bus.aluCmdOut       = r_aluCmd;
  assign bus.destOut         = r_dest;
  assign bus.src1Out         = r_src1;
  assign bus.src2Out         = r_src2;
  assign bus.shiftOperandOut = r_shiftOperand;
  assign bus.imm24Out        = r_imm24;
  assign bus.immOut          = r_imm;
  assign bus.memReadOut      = r_memRead;
  assign bus.memWriteEnOut   = r_memWriteEn;
  assign bus.wbEnOut         = r_wbEn;
  assign bus.branchOut       = r_branch;
  assign bus.sOut            = r_s;
  assign bus.bubbleCnt       = r_bubbleCnt;
  assign bus.freezeCnt       = r_freezeCnt;
endmodule

// File: tb/tb_reg_id_ex.sv
// Randomized + directed bench for reg_id_ex against a per-cycle entry model.
// A second instance with 4-bit counters exercises saturation.
module tb_reg_id_ex;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  alu;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [11:0] sh;
    logic [23:0] imm24;
    logic        imm;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        br;
    logic        s;
  } ent_t;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_err;
  ent_t        m_ent;
  int unsigned m_bub;
  int unsigned m_frz;

  reg_id_ex_if #(.DATA_W(32), .CNT_W(16)) ifm ();
  reg_id_ex_if #(.DATA_W(32), .CNT_W(4))  if4 ();

  reg_id_ex #(.DATA_W(32), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(ifm));
  reg_id_ex #(.DATA_W(32), .CNT_W(4))  dut_4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[154:0];
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic ent_t observed();
    ent_t o;
    o = {ifm.validOut, ifm.pcOut, ifm.regRnOut, ifm.regRmOut, ifm.aluCmdOut,
         ifm.destOut, ifm.src1Out, ifm.src2Out, ifm.shiftOperandOut, ifm.imm24Out,
         ifm.immOut, ifm.memReadOut, ifm.memWriteEnOut, ifm.wbEnOut,
         ifm.branchOut, ifm.sOut};
    return o;
  endfunction

  // One clock: drive inputs, advance the reference, compare every output.
  task automatic step(input logic r, input logic fl, input logic fz, input ent_t e);
    ent_t o;
    rst = r;
    ifm.flush = fl;  ifm.freeze = fz;  ifm.validIn = e.valid;
    if4.flush = fl;  if4.freeze = fz;  if4.validIn = e.valid;
    ifm.pcIn = e.pc;  ifm.regRnIn = e.rn;  ifm.regRmIn = e.rm;
    ifm.aluCmdIn = e.alu;  ifm.destIn = e.dest;  ifm.src1In = e.src1;
    ifm.src2In = e.src2;  ifm.shiftOperandIn = e.sh;  ifm.imm24In = e.imm24;
    ifm.immIn = e.imm;  ifm.memReadIn = e.mr;  ifm.memWriteEnIn = e.mw;
    ifm.wbEnIn = e.wb;  ifm.branchIn = e.br;  ifm.sIn = e.s;
    @(posedge clk);
    if (!r) begin
      m_ent = '0;  m_bub = 0;  m_frz = 0;
    end else if (fl || (!fz && !e.valid)) begin
      m_ent = '0;  m_bub++;
    end else if (fz) begin
      m_frz++;
    end else begin
      m_ent = e;
    end
    #1;
    o = observed();
    check("valid", {159'd0, o.valid}, {159'd0, m_ent.valid});
    check("pc", {128'd0, o.pc}, {128'd0, m_ent.pc});
    check("entry", {5'd0, o}, {5'd0, m_ent});
    check("bubbleCnt", {144'd0, ifm.bubbleCnt}, 160'(sat(m_bub, 65535)));
    check("freezeCnt", {144'd0, ifm.freezeCnt}, 160'(sat(m_frz, 65535)));
    check("bubbleCnt4", {156'd0, if4.bubbleCnt}, 160'(sat(m_bub, 15)));
    check("freezeCnt4", {156'd0, if4.freezeCnt}, 160'(sat(m_frz, 15)));
    check("ctrl_when_invalid",
          {159'd0, (!ifm.validOut && |{ifm.memReadOut, ifm.memWriteEnOut,
                                       ifm.wbEnOut, ifm.branchOut, ifm.sOut})},
          160'd0);
  endtask

  initial begin
    ent_t e;
    n_chk = 0;  n_err = 0;
    m_ent = '0;  m_bub = 0;  m_frz = 0;
    if4.pcIn = '0;  if4.regRnIn = '0;  if4.regRmIn = '0;  if4.aluCmdIn = '0;
    if4.destIn = '0;  if4.src1In = '0;  if4.src2In = '0;  if4.shiftOperandIn = '0;
    if4.imm24In = '0;  if4.immIn = 1'b0;  if4.memReadIn = 1'b0;
    if4.memWriteEnIn = 1'b0;  if4.wbEnIn = 1'b0;  if4.branchIn = 1'b0;  if4.sIn = 1'b0;

    // Reset held with random inputs, then first load after release.
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom), 1'($urandom), rand_ent());
    check("rst_valid", {159'd0, ifm.validOut}, 160'd0);
    check("rst_bubble", {144'd0, ifm.bubbleCnt}, 160'd0);
    e = rand_ent();  e.valid = 1'b1;  e.wb = 1'b1;  e.pc = 32'h4;  e.dest = 4'd1;
    step(1'b1, 1'b0, 1'b0, e);
    check("t1_pc", {128'd0, ifm.pcOut}, 160'h4);
    check("t1_valid", {159'd0, ifm.validOut}, 160'd1);
    e.pc = 32'h8;  e.dest = 4'd2;
    step(1'b1, 1'b0, 1'b0, e);
    check("t2_dest", {156'd0, ifm.destOut}, 160'd2);

    // Freeze while inputs keep changing.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, rand_ent());
    check("t3_pc", {128'd0, ifm.pcOut}, 160'h8);
    check("t3_freeze", {144'd0, ifm.freezeCnt}, 160'd3);
    check("t3_bubble", {144'd0, ifm.bubbleCnt}, 160'd0);
    e = rand_ent();  e.valid = 1'b1;  e.wb = 1'b1;  e.pc = 32'hC;  e.dest = 4'd3;
    step(1'b1, 1'b0, 1'b0, e);
    check("t2_pcC", {128'd0, ifm.pcOut}, 160'hC);
    check("t2_wb", {159'd0, ifm.wbEnOut}, 160'd1);

    // Flush overrides freeze.
    e = rand_ent();  e.valid = 1'b1;  e.mw = 1'b1;
    step(1'b1, 1'b1, 1'b1, e);
    check("t4_valid", {159'd0, ifm.validOut}, 160'd0);
    check("t4_mw", {159'd0, ifm.memWriteEnOut}, 160'd0);
    check("t4_rn", {128'd0, ifm.regRnOut}, 160'd0);
    check("t4_bubble", {144'd0, ifm.bubbleCnt}, 160'd1);
    check("t4_freeze", {144'd0, ifm.freezeCnt}, 160'd3);

    // Invalid ID entry loads as a bubble.
    e = rand_ent();  e.valid = 1'b0;  e.wb = 1'b1;  e.br = 1'b1;
    step(1'b1, 1'b0, 1'b0, e);
    check("t5_wb", {159'd0, ifm.wbEnOut}, 160'd0);
    check("t5_br", {159'd0, ifm.branchOut}, 160'd0);
    check("t5_bubble", {144'd0, ifm.bubbleCnt}, 160'd2);

    // Saturation of the 4-bit counter, then reset clears it.
    step(1'b0, 1'b0, 1'b0, rand_ent());
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, rand_ent());
    check("t6_sat", {156'd0, if4.bubbleCnt}, 160'd15);
    check("t6_wide", {144'd0, ifm.bubbleCnt}, 160'd20);
    step(1'b0, 1'b0, 1'b0, rand_ent());
    check("t6_clear", {156'd0, if4.bubbleCnt}, 160'd0);

    // Random traffic including occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      e = rand_ent();
      e.valid = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 31) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
